// File: rtl/baudgen_frac_if.sv
// Control/status bundle between a UART core (master) and the fractional baud generator (slave).
interface baudgen_frac_if #(
  parameter int unsigned W_INT  = 16,
  parameter int unsigned W_FRAC = 4,
  parameter int unsigned OS     = 16
);
  localparam int unsigned W_IDX = $clog2(OS);

  logic              clk_ena;
  logic              rx_mode;
  logic [W_INT-1:0]  div_int;
  logic [W_FRAC-1:0] div_frac;
  logic              div_wr;
  logic              div_pending;
  logic              os_tick;
  logic              baud_tick;
  logic [W_IDX-1:0]  os_idx;

  modport master (
    output clk_ena, rx_mode, div_int, div_frac, div_wr,
    input  div_pending, os_tick, baud_tick, os_idx
  );

  modport slave (
    input  clk_ena, rx_mode, div_int, div_frac, div_wr,
    output div_pending, os_tick, baud_tick, os_idx
  );
endinterface

// File: rtl/baudgen_frac.sv
// UART baud generator: integer+fractional divisor producing oversample and bit ticks,
// with a shadowed divisor that is swapped in only on a bit boundary while running.
module baudgen_frac #(
  parameter int unsigned       W_INT    = 16,
  parameter int unsigned       W_FRAC   = 4,
  parameter int unsigned       OS       = 16,
  parameter logic [W_INT-1:0]  DEF_INT  = W_INT'(54),
  parameter logic [W_FRAC-1:0] DEF_FRAC = W_FRAC'(4)
) (
  input  logic          clk,
  input  logic          rstn,
  baudgen_frac_if.slave bus
);
  localparam int unsigned      W_IDX    = $clog2(OS);
  localparam int unsigned      W_CNT    = W_INT + 1;
  localparam logic [W_IDX-1:0] IDX_LAST = W_IDX'(OS - 1);
  localparam logic [W_IDX-1:0] IDX_MID  = W_IDX'(OS / 2);
  localparam logic [W_CNT-1:0] MIN_DIV  = W_CNT'(2);

  typedef enum logic {ST_OFF, ST_RUN} state_e;

  state_e            state_q, state_d;
  logic [W_CNT-1:0]  cnt_q, cnt_d;
  logic [W_FRAC-1:0] acc_q, acc_d;
  logic              carry_q, carry_d;
  logic [W_INT-1:0]  int_q, int_d;
  logic [W_FRAC-1:0] frac_q, frac_d;
  logic [W_INT-1:0]  sh_int_q, sh_int_d;
  logic [W_FRAC-1:0] sh_frac_q, sh_frac_d;
  logic              pend_q, pend_d;
  logic              os_tick_q, os_tick_d;
  logic              baud_tick_q, baud_tick_d;
  logic [W_IDX-1:0]  idx_q, idx_d;

  logic [W_CNT-1:0]  int_eff;
  logic [W_CNT-1:0]  period;
  logic [W_FRAC:0]   acc_sum;
  logic [W_IDX-1:0]  idx_start;
  logic              apply;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    carry_d     = carry_q;
    int_d       = int_q;
    frac_d      = frac_q;
    sh_int_d    = sh_int_q;
    sh_frac_d   = sh_frac_q;
    pend_d      = pend_q;
    os_tick_d   = 1'b0;
    baud_tick_d = 1'b0;
    idx_d       = idx_q;
    apply       = 1'b0;

    // Divisors below 2 would make os_tick continuous, so they run as 2.
    int_eff   = ({1'b0, int_q} < MIN_DIV) ? MIN_DIV : {1'b0, int_q};
    period    = int_eff + W_CNT'(carry_q);
    acc_sum   = {1'b0, acc_q} + {1'b0, frac_q};
    idx_start = bus.rx_mode ? IDX_MID : '0;

    if (!bus.clk_ena) begin
      state_d = ST_OFF;
      cnt_d   = '0;
      acc_d   = '0;
      carry_d = 1'b0;
      idx_d   = idx_start;
      apply   = pend_q;
    end else begin
      case (state_q)
        ST_OFF: begin
          // The enabling edge already counts as the first cycle of the first period.
          state_d = ST_RUN;
          cnt_d   = W_CNT'(1);
          idx_d   = idx_start;
        end
        ST_RUN: begin
          if (cnt_q == period - W_CNT'(1)) begin
            cnt_d              = '0;
            os_tick_d          = 1'b1;
            idx_d              = idx_q + 1'b1;
            {carry_d, acc_d}   = acc_sum;
            baud_tick_d        = (idx_q == IDX_LAST);
            if (baud_tick_d && pend_q) begin
              apply   = 1'b1;
              acc_d   = '0;
              carry_d = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + W_CNT'(1);
          end
        end
        default: state_d = ST_OFF;
      endcase
    end

    // Apply reads the old shadow, so a write in the same cycle stays pending.
    if (apply) begin
      int_d  = sh_int_q;
      frac_d = sh_frac_q;
      pend_d = 1'b0;
    end
    if (bus.div_wr) begin
      sh_int_d  = bus.div_int;
      sh_frac_d = bus.div_frac;
      pend_d    = 1'b1;
    end
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_OFF;
      cnt_q       <= '0;
      acc_q       <= '0;
      carry_q     <= 1'b0;
      int_q       <= DEF_INT;
      frac_q      <= DEF_FRAC;
      // NOTE: the shadow is reset too, so a stray apply can never load X.
      sh_int_q    <= DEF_INT;
      sh_frac_q   <= DEF_FRAC;
      pend_q      <= 1'b0;
      os_tick_q   <= 1'b0;
      baud_tick_q <= 1'b0;
      idx_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      carry_q     <= carry_d;
      int_q       <= int_d;
      frac_q      <= frac_d;
      sh_int_q    <= sh_int_d;
      sh_frac_q   <= sh_frac_d;
      pend_q      <= pend_d;
      os_tick_q   <= os_tick_d;
      baud_tick_q <= baud_tick_d;
      idx_q       <= idx_d;
    end
  end

  assign bus.os_tick     = os_tick_q;
  assign bus.baud_tick   = baud_tick_q;
  assign bus.os_idx      = idx_q;
  assign bus.div_pending = pend_q;
endmodule

// File: tb/tb_baudgen_frac.sv
// Bench for baudgen_frac (OS=4): tick timing predicted from the closed-form schedule
// tick m of a divisor segment lands at start + m*I + floor((m-1)*F/2^W_FRAC).
module tb_baudgen_frac;
  localparam int W_INT    = 16;
  localparam int W_FRAC   = 4;
  localparam int OS       = 4;
  localparam int W_IDX    = $clog2(OS);
  localparam int DEF_INT  = 54;
  localparam int DEF_FRAC = 4;
  localparam int N_MAX    = 400;
  localparam int MAX_WR   = 3;

  typedef logic [W_IDX+2:0] snap_t;  // {os_tick, baud_tick, div_pending, os_idx}

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  baudgen_frac_if #(.W_INT(W_INT), .W_FRAC(W_FRAC), .OS(OS)) bus ();

  baudgen_frac #(
    .W_INT(W_INT), .W_FRAC(W_FRAC), .OS(OS),
    .DEF_INT(W_INT'(DEF_INT)), .DEF_FRAC(W_FRAC'(DEF_FRAC))
  ) dut (
    .clk(clk), .rstn(rstn), .bus(bus)
  );

  int    n_checks = 0;
  int    n_fail   = 0;
  snap_t obs_v [N_MAX+1];
  snap_t exp_v [N_MAX+1];
  int    n_wr;
  int    wr_edge [MAX_WR];
  int    wr_i    [MAX_WR];
  int    wr_f    [MAX_WR];

  // Edge n is the n-th rising edge after the one that first samples clk_ena=1;
  // a write at edge n means div_wr is sampled 1 at that edge.
  task automatic build_model(input int i0, input int f0, input bit rx, input int n_edges);
    int cur_i, cur_f, seg, k, idx, nxt, sh_i, sh_f;
    bit pend, tick, baud;
    cur_i = (i0 < 2) ? 2 : i0;
    cur_f = f0;
    seg = 0; k = 0; pend = 0; sh_i = i0; sh_f = f0;
    idx = rx ? OS / 2 : 0;
    nxt = cur_i;
    for (int n = 1; n <= n_edges; n++) begin
      tick = (n == nxt);
      baud = 1'b0;
      if (tick) begin
        k++;
        idx  = (idx + 1) % OS;
        baud = (idx == 0);
        if (baud && pend) begin
          cur_i = (sh_i < 2) ? 2 : sh_i;
          cur_f = sh_f;
          seg = n; k = 0; pend = 0;
        end
        nxt = seg + (k + 1) * cur_i + (k * cur_f) / (1 << W_FRAC);
      end
      for (int j = 0; j < n_wr; j++)
        if (wr_edge[j] == n - 1) begin
          sh_i = wr_i[j]; sh_f = wr_f[j]; pend = 1;
        end
      exp_v[n] = {tick, baud, pend, W_IDX'(idx)};
    end
  endtask

  task automatic load_div(input int i, input int f);
    @(negedge clk);
    bus.clk_ena = 1'b0;
    bus.div_wr  = 1'b1;
    bus.div_int = W_INT'(i);
    bus.div_frac = W_FRAC'(f);
    @(negedge clk);
    bus.div_wr = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Enables the DUT for n_edges edges, recording outputs; leaves clk_ena low at the end.
  task automatic run(input bit do_load, input int i0, input int f0, input bit rx, input int n_edges);
    if (do_load) load_div(i0, f0);
    build_model(i0, f0, rx, n_edges);
    @(negedge clk);
    bus.rx_mode = rx;
    bus.clk_ena = 1'b1;
    bus.div_wr  = 1'b0;
    for (int n = 1; n <= n_edges; n++) begin
      @(negedge clk);
      obs_v[n] = {bus.os_tick, bus.baud_tick, bus.div_pending, bus.os_idx};
      bus.div_wr = 1'b0;
      for (int j = 0; j < n_wr; j++)
        if (wr_edge[j] == n) begin
          bus.div_wr   = 1'b1;
          bus.div_int  = W_INT'(wr_i[j]);
          bus.div_frac = W_FRAC'(wr_f[j]);
        end
    end
    bus.clk_ena = 1'b0;
    bus.div_wr  = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.os_tick, bus.baud_tick, bus.div_pending, bus.os_idx} !== snap_t'(0)) begin
      n_fail++;
      $display("FAIL reset_state got=%b exp=%b",
               {bus.os_tick, bus.baud_tick, bus.div_pending, bus.os_idx}, snap_t'(0));
    end
    rstn = 1'b1;
    bus.rx_mode = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.os_idx !== W_IDX'(OS / 2)) begin
      n_fail++;
      $display("FAIL disabled_rx_idx got=%0d exp=%0d", bus.os_idx, OS / 2);
    end
    bus.rx_mode = 1'b0;
    bus.div_wr = 1'b1; bus.div_int = W_INT'(4); bus.div_frac = '0;
    @(negedge clk);
    bus.div_wr = 1'b0;
    n_checks++;
    if (bus.os_idx !== '0 || bus.div_pending !== 1'b1) begin
      n_fail++;
      $display("FAIL disabled_write_set idx=%0d pend=%b exp idx=0 pend=1", bus.os_idx, bus.div_pending);
    end
    @(negedge clk);
    n_checks++;
    if (bus.div_pending !== 1'b0) begin
      n_fail++;
      $display("FAIL disabled_write_apply pend got=%b exp=0", bus.div_pending);
    end
  endtask

  task automatic test_tx_rx();
    n_wr = 0;
    for (int m = 0; m < 2; m++) begin
      run(1, 4, 0, m[0], 48);
      for (int n = 1; n <= 48; n++) begin
        n_checks++;
        if (obs_v[n] !== exp_v[n]) begin
          n_fail++;
          $display("FAIL %s edge=%0d tick/baud/pend/idx got=%b exp=%b",
                   m == 0 ? "tx_int4" : "rx_int4", n, obs_v[n], exp_v[n]);
        end
      end
    end
  endtask

  task automatic test_frac();
    int cnt, e33;
    n_wr = 0;
    run(1, 4, 8, 0, 160);
    cnt = 0; e33 = -1;
    for (int n = 1; n <= 160; n++) begin
      n_checks++;
      if (obs_v[n] !== exp_v[n]) begin
        n_fail++;
        $display("FAIL frac_4_8 edge=%0d got=%b exp=%b", n, obs_v[n], exp_v[n]);
      end
      if (obs_v[n][W_IDX+2]) begin
        cnt++;
        if (cnt == 33) e33 = n;
      end
    end
    n_checks++;
    if (e33 != 33 * 4 + 16) begin
      n_fail++;
      $display("FAIL frac_span33 got=%0d exp=%0d", e33, 33 * 4 + 16);
    end
  endtask

  task automatic test_midbit_write();
    n_wr = 1;
    wr_edge[0] = 6; wr_i[0] = 6; wr_f[0] = 0;
    run(1, 4, 0, 0, 60);
    for (int n = 1; n <= 60; n++) begin
      n_checks++;
      if (obs_v[n] !== exp_v[n]) begin
        n_fail++;
        $display("FAIL midbit_write edge=%0d got=%b exp=%b", n, obs_v[n], exp_v[n]);
      end
    end
  endtask

  task automatic test_clamp();
    int consec;
    n_wr = 0;
    for (int iv = 0; iv < 2; iv++) begin
      run(1, iv, 0, 0, 24);
      consec = 0;
      for (int n = 1; n <= 24; n++) begin
        n_checks++;
        if (obs_v[n] !== exp_v[n]) begin
          n_fail++;
          $display("FAIL clamp_int%0d edge=%0d got=%b exp=%b", iv, n, obs_v[n], exp_v[n]);
        end
        if (n > 1 && obs_v[n][W_IDX+2] && obs_v[n-1][W_IDX+2]) consec++;
      end
      n_checks++;
      if (consec != 0) begin
        n_fail++;
        $display("FAIL clamp_int%0d_consecutive got=%0d exp=0", iv, consec);
      end
    end
  endtask

  task automatic test_back_to_back();
    n_wr = 3;
    wr_edge[0] = 5;  wr_i[0] = 7; wr_f[0] = 0;
    wr_edge[1] = 9;  wr_i[1] = 6; wr_f[1] = 0;
    wr_edge[2] = 15; wr_i[2] = 3; wr_f[2] = 0;
    run(1, 4, 0, 0, 80);
    for (int n = 1; n <= 80; n++) begin
      n_checks++;
      if (obs_v[n] !== exp_v[n]) begin
        n_fail++;
        $display("FAIL back_to_back edge=%0d got=%b exp=%b", n, obs_v[n], exp_v[n]);
      end
    end
  endtask

  task automatic test_disable_reset();
    int first;
    n_wr = 0;
    run(1, 4, 0, 0, 11);
    @(negedge clk);
    n_checks++;
    if ({bus.os_tick, bus.baud_tick, bus.div_pending, bus.os_idx} !== snap_t'(0)) begin
      n_fail++;
      $display("FAIL disable_midbit got=%b exp=%b",
               {bus.os_tick, bus.baud_tick, bus.div_pending, bus.os_idx}, snap_t'(0));
    end
    run(1, 4, 0, 0, 20);
    for (int n = 1; n <= 20; n++) begin
      n_checks++;
      if (obs_v[n] !== exp_v[n]) begin
        n_fail++;
        $display("FAIL reenable edge=%0d got=%b exp=%b", n, obs_v[n], exp_v[n]);
      end
    end
    n_wr = 1;
    wr_edge[0] = 3; wr_i[0] = 6; wr_f[0] = 0;
    run(1, 4, 0, 0, 7);
    rstn = 1'b0;
    #1;
    n_checks++;
    if ({bus.os_tick, bus.baud_tick, bus.div_pending, bus.os_idx} !== snap_t'(0)) begin
      n_fail++;
      $display("FAIL reset_midrun got=%b exp=%b",
               {bus.os_tick, bus.baud_tick, bus.div_pending, bus.os_idx}, snap_t'(0));
    end
    @(negedge clk);
    rstn = 1'b1;
    n_wr = 0;
    run(0, DEF_INT, DEF_FRAC, 0, 120);
    first = -1;
    for (int n = 1; n <= 120; n++) begin
      n_checks++;
      if (obs_v[n] !== exp_v[n]) begin
        n_fail++;
        $display("FAIL def_divisor edge=%0d got=%b exp=%b", n, obs_v[n], exp_v[n]);
      end
      if (first < 0 && obs_v[n][W_IDX+2]) first = n;
    end
    n_checks++;
    if (first != DEF_INT) begin
      n_fail++;
      $display("FAIL def_first_tick got=%0d exp=%0d", first, DEF_INT);
    end
  endtask

  task automatic test_random();
    int i0, f0, e;
    bit rx;
    for (int it = 0; it < 6; it++) begin
      i0 = $urandom_range(0, 9);
      f0 = $urandom_range(0, 15);
      rx = 1'($urandom_range(0, 1));
      n_wr = $urandom_range(0, MAX_WR);
      e = $urandom_range(1, 30);
      for (int j = 0; j < n_wr; j++) begin
        wr_edge[j] = e;
        wr_i[j] = $urandom_range(0, 9);
        wr_f[j] = $urandom_range(0, 15);
        e += $urandom_range(1, 25);
      end
      run(1, i0, f0, rx, 300);
      for (int n = 1; n <= 300; n++) begin
        n_checks++;
        if (obs_v[n] !== exp_v[n]) begin
          n_fail++;
          $display("FAIL random%0d(i=%0d f=%0d rx=%0d) edge=%0d got=%b exp=%b",
                   it, i0, f0, rx, n, obs_v[n], exp_v[n]);
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    bus.clk_ena = 1'b0;
    bus.rx_mode = 1'b0;
    bus.div_wr = 1'b0;
    bus.div_int = '0;
    bus.div_frac = '0;
    test_reset();
    test_tx_rx();
    test_frac();
    test_midbit_write();
    test_clamp();
    test_back_to_back();
    test_disable_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/baudgen_frac.md
Name: baudgen_frac

Overview:
- Next-generation UART baud generator with a run-time programmable divisor, including a fractional part.
- Produces an oversampling tick (OS per bit) and a bit tick. The bit tick can be TX-aligned (at bit boundary) or RX-aligned (at mid-bit).
- Sits between the UART TX/RX state machines and the system clock. Allows baud changes without resynthesis.

Parameters:
- W_INT, 16, width of integer divisor field (clock cycles per oversample period).
- W_FRAC, 4, width of fractional divisor field (units of 1/2^W_FRAC cycle).
- OS, 16, oversample ticks per bit; power of 2, >= 2.
- DEF_INT, 54, integer divisor loaded at reset (100 MHz, 115200 baud, OS=16).
- DEF_FRAC, 4, fractional divisor loaded at reset.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- clk_ena  in  1  1 = run; 0 = counters held cleared, no ticks
- rx_mode  in  1  0 = TX alignment, 1 = RX (mid-bit) alignment; sampled only on the clk_ena 0->1 edge
- div_int  in  W_INT  new integer divisor
- div_frac  in  W_FRAC  new fractional divisor
- div_wr  in  1  one-cycle strobe; captures div_int/div_frac into shadow
- div_pending  out  1  shadow written but not yet applied
- os_tick  out  1  one-cycle pulse per oversample period
- baud_tick  out  1  one-cycle pulse per bit
- os_idx  out  clog2(OS)  oversample phase within current bit

Behaviour:
- All outputs registered.
- Reset (async, rstn=0): os_tick=0, baud_tick=0, os_idx=0, div_pending=0; active divisor=DEF_INT/DEF_FRAC; fractional accumulator acc=0; period counter=0.
- Integer clamp: the applied integer divisor is max(div_int,2). Values 0/1 are stored but act as 2.
- clk_ena=0:
  - period counter=0, acc=0, os_tick=0, baud_tick=0.
  - os_idx=0 if rx_mode=0, OS/2 if rx_mode=1.
- Period length P:
  - First period after enable = active int.
  - At each os_tick, acc <= acc + frac (W_FRAC bits, wraps).
  - Next period = int + carry-out of that addition.
  - Mean period = int + frac/2^W_FRAC cycles.
- Timing reference: clk_ena first sampled 1 at edge 0.
  - os_tick is sampled 1 at edge P0, P0+P1, ...
  - Never two consecutive cycles high.
- os_idx:
  - Increments mod OS on each os_tick (updates in the same cycle os_tick is high).
  - baud_tick asserted in the cycle where os_idx wraps OS-1 -> 0.
  - TX mode: first baud_tick at the OS-th os_tick.
  - RX mode: os_idx starts at OS/2, so first baud_tick at the (OS/2)-th os_tick (mid start bit), then every OS os_ticks.
- clk_ena 1->0 mid-bit: at the next edge all counters return to the disabled state and ticks go low. No partial pulse is carried over to the next enable.
- Divisor update:
  - div_wr captures shadow and sets div_pending=1.
  - If clk_ena=0: shadow applied at the next edge, div_pending cleared.
  - If clk_ena=1: applied at the edge where baud_tick is asserted (bit boundary); acc cleared; div_pending cleared. The bit in progress completes with the old divisor.
  - div_wr while pending: shadow overwritten, pending stays 1. Only the last write is applied.
  - div_wr in the same cycle as an apply: the old shadow is applied, the new value is captured, div_pending stays 1.
- rstn asserted mid-run: immediate return to reset values, including the DEF divisor. The pending shadow is discarded.

Test Plan:
- Reset, write div_int=4 div_frac=0 (OS=4 override), TX, enable -> os_tick at edges 4,8,12,...; baud_tick at 16,32; os_idx sequence 1,2,3,0.
- Same divisor, rx_mode=1 -> first baud_tick at edge 8, then 24, 40; os_tick spacing unchanged.
- div_int=4 div_frac=8, W_FRAC=4 -> period sequence 4,4,5,4,5...; 32 os_ticks span exactly 4+31*4+15=143... → bench checks: sum of first 33 periods = 33*4+16 = 148 cycles.
- Running at div_int=4, write div_int=6 mid-bit -> div_pending=1 until next baud_tick; the remaining os_ticks of that bit are 4 apart, then 6 apart.
- div_int=0 and div_int=1 -> os_tick every 2 cycles, never continuous high.
- Drop clk_ena mid-bit, then rstn low mid-run with a pending write -> ticks stop next edge. After reset: div_pending=0 and the DEF divisor is used (first os_tick at edge 54 after enable).
